// File: rtl/ctrl_request_engine.sv
// ctrl_request_engine
// Class-request engine for the endpoint-0 control path. A latched 8-byte setup
// packet is decoded; GET_CUR / GET_LEN / GET_INFO responses are streamed out
// as bytes under valid/ready, SET_CUR payloads are collected byte by byte, and
// every other request is answered with a stall.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   enable, data      setup strobe (sampled in IDLE) and the 64-bit setup packet
//   param_block       current values, control n at [n*PARAM_BYTES*8 +: PARAM_BYTES*8]
//   info_block        GET_INFO byte of control n at [n*8 +: 8]
//   busy              high whenever the engine is not idle
//   tx_data/valid/ready/last   IN response byte stream
//   rx_data/valid     OUT payload byte stream (always accepted in RX)
//   stall, done, set_valid     one-cycle completion pulses
//   set_ctrl, set_data         control index and payload of the last SET_CUR
module ctrl_request_engine #(
  parameter int NUM_CTRL    = 4,
  parameter int PARAM_BYTES = 8,
  parameter int CTRL_W      = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [63:0]                     data,
  input  logic [NUM_CTRL*PARAM_BYTES*8-1:0] param_block,
  input  logic [NUM_CTRL*8-1:0]           info_block,
  output logic                            busy,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  output logic                            tx_last,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_valid,
  output logic                            stall,
  output logic                            done,
  output logic                            set_valid,
  output logic [CTRL_W-1:0]               set_ctrl,
  output logic [PARAM_BYTES*8-1:0]        set_data
);

  localparam int PW = PARAM_BYTES * 8;
  // GET_LEN needs two bytes even when the parameter block is a single byte.
  localparam int BUF_W = (PARAM_BYTES > 2) ? PW : 16;
  localparam logic [15:0] PB_LEN       = 16'(PARAM_BYTES);
  localparam logic [8:0]  NUM_CTRL_LIM = 9'(NUM_CTRL);
  localparam logic [7:0]  RX_LAST_IDX  = 8'(PARAM_BYTES - 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_TX, S_RX, S_DONE} state_t;
  state_t state_reg, state_next;

  // Only the setup fields the engine uses are latched; wIndex and wValue[7:0]
  // carry nothing for this class of request.
  logic [7:0]  req_type_reg, req_code_reg, ctrl_raw_reg;
  logic [15:0] wlength_reg;
  logic        unused_setup_bits;
  assign unused_setup_bits = ^data[39:16];

  logic [BUF_W-1:0]  resp_buf_reg;
  logic [15:0]       tx_cnt_reg;
  logic [7:0]        rx_cnt_reg;
  logic [PW-1:0]     shadow_reg, shadow_next, set_data_reg;
  logic [PW+7:0]     rx_cat;
  logic [CTRL_W-1:0] set_ctrl_reg;
  logic              stall_pend_reg, set_pend_reg;

  // Per-control views of the flat input buses.
  logic [PW-1:0] param_arr [NUM_CTRL];
  logic [7:0]    info_arr  [NUM_CTRL];
  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
    assign param_arr[gi] = param_block[gi*PW +: PW];
    assign info_arr[gi]  = info_block[gi*8 +: 8];
  end

  // Request decode, evaluated from the latched setup fields.
  logic              ctrl_ok, is_get_cur, is_get_len, is_get_info, is_set_cur;
  logic              accept_in, accept_set, tx_final, rx_final;
  logic [CTRL_W-1:0] ctrl_idx;
  logic [15:0]       nat_len, send_len;
  logic [BUF_W-1:0]  resp_fill;

  assign ctrl_idx    = ctrl_raw_reg[CTRL_W-1:0];
  assign ctrl_ok     = {1'b0, ctrl_raw_reg} < NUM_CTRL_LIM;
  assign is_get_cur  = (req_type_reg == 8'hA1) && (req_code_reg == 8'h81);
  assign is_get_len  = (req_type_reg == 8'hA1) && (req_code_reg == 8'h86);
  assign is_get_info = (req_type_reg == 8'hA1) && (req_code_reg == 8'h87);
  assign is_set_cur  = (req_type_reg == 8'h21) && (req_code_reg == 8'h01);
  assign accept_in   = (is_get_cur || is_get_len || is_get_info) && ctrl_ok;
  assign accept_set  = is_set_cur && ctrl_ok && (wlength_reg == PB_LEN);
  assign send_len    = (wlength_reg < nat_len) ? wlength_reg : nat_len;
  assign tx_final    = (tx_cnt_reg == 16'd1);
  assign rx_final    = (rx_cnt_reg == RX_LAST_IDX);
  // Payload shifts in from the top so the first byte ends up in the LSB.
  assign rx_cat      = {rx_data, shadow_reg};
  assign shadow_next = rx_cat[PW+7:8];

  always_comb begin
    nat_len   = 16'd0;
    resp_fill = '0;
    if (is_get_cur) begin
      nat_len         = PB_LEN;
      resp_fill[PW-1:0] = param_arr[ctrl_idx];
    end else if (is_get_len) begin
      nat_len          = 16'd2;
      resp_fill[15:0]  = {8'h00, PB_LEN[7:0]};
    end else if (is_get_info) begin
      nat_len          = 16'd1;
      resp_fill[7:0]   = info_arr[ctrl_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b1;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    stall      = 1'b0;
    done       = 1'b0;
    set_valid  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (enable) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (accept_in && send_len != 16'd0) state_next = S_TX;
        else if (accept_set)                state_next = S_RX;
        else                                state_next = S_DONE;
      end
      S_TX: begin
        tx_valid = 1'b1;
        tx_last  = tx_final;
        if (tx_ready && tx_final) state_next = S_DONE;
      end
      S_RX: begin
        if (rx_valid && rx_final) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        stall      = stall_pend_reg;
        set_valid  = set_pend_reg;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_type_reg   <= '0;
      req_code_reg   <= '0;
      ctrl_raw_reg   <= '0;
      wlength_reg    <= '0;
      resp_buf_reg   <= '0;
      tx_cnt_reg     <= '0;
      rx_cnt_reg     <= '0;
      shadow_reg     <= '0;
      set_data_reg   <= '0;
      set_ctrl_reg   <= '0;
      stall_pend_reg <= 1'b0;
      set_pend_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (enable) begin
            req_type_reg <= data[63:56];
            req_code_reg <= data[55:48];
            ctrl_raw_reg <= data[47:40];
            wlength_reg  <= data[15:0];
          end
        end
        S_DECODE: begin
          // Snapshot so later param/info changes cannot tear the response.
          resp_buf_reg   <= resp_fill;
          tx_cnt_reg     <= send_len;
          rx_cnt_reg     <= 8'd0;
          stall_pend_reg <= !(accept_in || accept_set);
          set_pend_reg   <= 1'b0;
        end
        S_TX: begin
          if (tx_ready) begin
            resp_buf_reg <= resp_buf_reg >> 8;
            tx_cnt_reg   <= tx_cnt_reg - 16'd1;
          end
        end
        S_RX: begin
          if (rx_valid) begin
            shadow_reg <= shadow_next;
            rx_cnt_reg <= rx_cnt_reg + 8'd1;
            if (rx_final) begin
              set_data_reg <= shadow_next;
              set_ctrl_reg <= ctrl_idx;
              set_pend_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tx_data  = tx_valid ? resp_buf_reg[7:0] : 8'h00;
  assign set_ctrl = set_ctrl_reg;
  assign set_data = set_data_reg;

endmodule

// File: tb/tb_ctrl_request_engine.sv
module tb_ctrl_request_engine;
  localparam int NUM_CTRL    = 4;
  localparam int PARAM_BYTES = 8;
  localparam int CTRL_W      = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                              rst, enable, tx_ready, rx_valid;
  logic [63:0]                       data;
  logic [NUM_CTRL*PARAM_BYTES*8-1:0] param_block;
  logic [NUM_CTRL*8-1:0]             info_block;
  logic [7:0]                        rx_data;
  logic                              busy, tx_valid, tx_last, stall, done, set_valid;
  logic [7:0]                        tx_data;
  logic [CTRL_W-1:0]                 set_ctrl;
  logic [PARAM_BYTES*8-1:0]          set_data;

  ctrl_request_engine #(.NUM_CTRL(NUM_CTRL), .PARAM_BYTES(PARAM_BYTES)) dut (
    .clk(clk), .rst(rst), .enable(enable), .data(data),
    .param_block(param_block), .info_block(info_block),
    .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_last(tx_last), .rx_data(rx_data), .rx_valid(rx_valid),
    .stall(stall), .done(done), .set_valid(set_valid),
    .set_ctrl(set_ctrl), .set_data(set_data)
  );

  int checks = 0;
  int errors = 0;
  logic [8:0] sb[$];   // expected {byte, last}

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Byte monitor: every handshake pops the scoreboard; held bytes must stay put.
  logic       hold_prev = 1'b0;
  logic [8:0] hold_val  = '0;
  always @(negedge clk) begin
    if (hold_prev) chk("hold", {tx_valid, tx_data, tx_last}, {1'b1, hold_val});
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      chk("unexpected_byte", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) chk("tx_byte", {tx_data, tx_last}, sb.pop_front());
    end
    hold_prev = (tx_valid === 1'b1) && (tx_ready === 1'b0) && (rst === 1'b0);
    hold_val  = {tx_data, tx_last};
  end

  task automatic send(input logic [63:0] pkt);
    @(posedge clk); #1;
    data = pkt; enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  // Waits (bounded) for done; cycle 1 is the DECODE cycle after the enable edge.
  task automatic wait_done(input string tag, input bit exp_stall, input bit exp_set,
                           input int exp_cycle);
    int n = 0;
    bit seen_done = 0, seen_tx = 0;
    while (!seen_done && n < 200) begin
      @(negedge clk); n++;
      if (n == 1) chk({tag, "_busy"}, 64'(busy), 64'd1);
      if (tx_valid === 1'b1) seen_tx = 1;
      if (done === 1'b1) seen_done = 1;
    end
    chk({tag, "_done_seen"}, 64'(seen_done), 64'd1);
    if (exp_cycle > 0) chk({tag, "_done_cycle"}, 64'(n), 64'(exp_cycle));
    chk({tag, "_stall"}, 64'(stall), 64'(exp_stall));
    chk({tag, "_set_valid"}, 64'(set_valid), 64'(exp_set));
    chk({tag, "_tx_valid_in_done"}, 64'(tx_valid), 64'd0);
    if (exp_stall) chk({tag, "_no_tx"}, 64'(seen_tx), 64'd0);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    @(negedge clk);
    chk({tag, "_idle"}, {busy, done}, 64'd0);
    $display("txn %s: done at cycle %0d stall=%0b set_valid=%0b", tag, n, stall, set_valid);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, 64'({busy, tx_valid, tx_last, stall, done, set_valid, tx_data, set_ctrl}), 64'd0);
    chk({tag, "_set_data"}, set_data, 64'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; data = '0; tx_ready = 1'b1;
    rx_valid = 1'b0; rx_data = '0;
    param_block = {64'hF0E0D0C0B0A09080, 64'h8877665544332211,
                   64'h1716151413121110, 64'h0706050403020100};
    info_block  = 32'h44660355;
    @(posedge clk); @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // GET_INFO ctrl 1
    sb.push_back({8'h03, 1'b1});
    send({8'hA1, 8'h87, 16'h0100, 16'h0000, 16'h0002});
    wait_done("get_info", 0, 0, 3);

    // GET_CUR ctrl 2 truncated to 3 bytes
    sb.push_back({8'h11, 1'b0}); sb.push_back({8'h22, 1'b0}); sb.push_back({8'h33, 1'b1});
    send({8'hA1, 8'h81, 16'h0200, 16'h0000, 16'h0003});
    wait_done("get_cur_w3", 0, 0, 5);

    // GET_CUR ctrl 2 with wLength 64; inputs change mid-transfer
    for (int i = 0; i < 8; i++) sb.push_back({8'(8'h11 * (i + 1)), (i == 7)});
    send({8'hA1, 8'h81, 16'h0200, 16'h0000, 16'h0040});
    fork
      begin
        @(posedge clk); #1; @(posedge clk); #1;
        param_block = ~param_block;
      end
      wait_done("get_cur_w64", 0, 0, 10);
    join
    param_block = ~param_block;

    // GET_LEN with backpressure 1-0-0-1
    tx_ready = 1'b0;
    sb.push_back({8'h08, 1'b0}); sb.push_back({8'h00, 1'b1});
    send({8'hA1, 8'h86, 16'h0000, 16'h0000, 16'h0002});
    fork
      begin
        @(posedge clk); #1 tx_ready = 1'b1;
        @(posedge clk); #1 tx_ready = 1'b0;
        @(posedge clk); #1 tx_ready = 1'b0;
        @(posedge clk); #1 tx_ready = 1'b1;
      end
      wait_done("get_len_bp", 0, 0, 6);
    join

    // Rejects and zero-length IN
    send({8'hA1, 8'h83, 16'h0100, 16'h0000, 16'h0008});
    wait_done("rej_breq83", 1, 0, 2);
    send({8'hA1, 8'h81, 16'h0400, 16'h0000, 16'h0008});
    wait_done("rej_ctrl4", 1, 0, 2);
    send({8'hA2, 8'h81, 16'h0100, 16'h0000, 16'h0008});
    wait_done("rej_type_a2", 1, 0, 2);
    send({8'h21, 8'h01, 16'h0100, 16'h0000, 16'h0004});
    wait_done("rej_set_w4", 1, 0, 2);
    send({8'hA1, 8'h81, 16'h0100, 16'h0000, 16'h0000});
    wait_done("get_cur_w0", 0, 0, 2);

    // SET_CUR ctrl 1 with gaps between payload bytes
    send({8'h21, 8'h01, 16'h0100, 16'h0000, 16'h0008});
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'(i + 1);
          if (i % 2 == 1) begin @(posedge clk); #1 rx_valid = 1'b0; end
        end
        @(posedge clk); #1 rx_valid = 1'b0;
      end
      wait_done("set_cur", 0, 1, -1);
    join
    chk("set_ctrl", 64'(set_ctrl), 64'd1);
    chk("set_data", set_data, 64'h0807060504030201);

    // Reset after two bytes of GET_CUR ctrl 2
    sb.push_back({8'h11, 1'b0}); sb.push_back({8'h22, 1'b0});
    send({8'hA1, 8'h81, 16'h0200, 16'h0000, 16'h0008});
    @(posedge clk); #1; @(posedge clk); #1;
    @(posedge clk); #1 tx_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("mid_reset");
    chk("mid_reset_sb", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_reset_no_done", 64'({done, set_valid, busy}), 64'd0);
    end
    $display("txn mid_reset: aborted after 2 bytes");
    tx_ready = 1'b1;
    sb.push_back({8'h03, 1'b1});
    send({8'hA1, 8'h87, 16'h0100, 16'h0000, 16'h0002});
    wait_done("get_info_after_reset", 0, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ctrl_request_engine.md
# ctrl_request_engine

Parametrised class-request engine for the endpoint-0 control path. It decodes a latched 64-bit setup packet and serves GET_CUR, GET_LEN and GET_INFO requests for up to NUM_CTRL controls, streaming the response as bytes under valid/ready backpressure. It also accepts SET_CUR payloads and stalls every unsupported request. It sits between the setup-packet capture logic and the endpoint-0 IN/OUT byte paths, and supersedes the fixed-width 16/32/64-bit parameter-block outputs.

## Interface
Parameters:
- NUM_CTRL, default 4: number of addressable controls (1..255).
- PARAM_BYTES, default 8: size in bytes of each control's parameter block (1..255).
- CTRL_W, default $clog2(NUM_CTRL) (minimum 1): width of the control index.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- rst  in  1  reset; synchronous, active-high.
- enable  in  1  setup strobe. Sampled only in IDLE.
- data  in  64  setup packet:
  - bmRequestType = [63:56]
  - bRequest = [55:48]
  - wValue = [47:32]
  - wIndex = [31:16]
  - wLength = [15:0]
- param_block  in  NUM_CTRL*PARAM_BYTES*8  current values.
  - Control n occupies [n*PARAM_BYTES*8 +: PARAM_BYTES*8].
  - Byte 0 is the LSB.
- info_block  in  NUM_CTRL*8  GET_INFO byte of control n at [n*8 +: 8].
- busy  out  1  high in every state except IDLE.
- tx_data  out  8  IN response byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte. A transfer occurs when tx_valid && tx_ready.
- tx_last  out  1  marks the final response byte.
- rx_data  in  8  OUT payload byte.
- rx_valid  in  1  rx_data is valid. Always accepted while in RX.
- stall  out  1  one-cycle pulse: request rejected.
- done  out  1  one-cycle pulse: request finished, whether it succeeded or stalled.
- set_valid  out  1  one-cycle pulse: SET_CUR payload complete.
- set_ctrl  out  CTRL_W  control index of the last SET_CUR. Held until the next SET_CUR.
- set_data  out  PARAM_BYTES*8  payload of the last SET_CUR, byte 0 = first received, in the LSB. Held until the next SET_CUR.

## Operation
- Control index: ctrl = wValue[15:8]. Valid only if ctrl < NUM_CTRL. wIndex is ignored.
- Supported requests (anything else, or an invalid ctrl, stalls):
  - bmRequestType 0xA1, bRequest 0x81 (GET_CUR): natural length N = PARAM_BYTES. Sends param_block bytes of ctrl, byte 0 first.
  - bmRequestType 0xA1, bRequest 0x86 (GET_LEN): N = 2. Sends PARAM_BYTES little-endian (low byte, then 0x00).
  - bmRequestType 0xA1, bRequest 0x87 (GET_INFO): N = 1. Sends info_block byte of ctrl.
  - bmRequestType 0x21, bRequest 0x01 (SET_CUR): requires wLength == PARAM_BYTES; otherwise stalls.
- IN length: bytes sent = min(wLength, N). The comparison is 16-bit unsigned; wLength larger than N never extends the response.
- IN with wLength == 0: no bytes are sent and no stall is raised; the engine goes straight to DONE.
- FSM states: IDLE, DECODE, TX, RX, DONE.
- IDLE -> DECODE when enable = 1. data is latched on that edge. enable is ignored in every other state.
- DECODE:
  - Snapshots the selected param_block/info_block into a response buffer; mid-transfer input changes do not tear the response.
  - Loads the byte counter.
  - Goes to TX, RX, or DONE (stall or zero length).
- TX: the byte counter advances on each handshake. After the handshake on the tx_last byte -> DONE.
- RX:
  - Each rx_valid byte is written into a shadow register at the next little-endian position.
  - After PARAM_BYTES bytes -> DONE. On that same edge, set_data/set_ctrl are updated and set_valid is armed.
- DONE: lasts one cycle. Asserts done, plus stall if rejected, plus set_valid if SET_CUR completed. Then -> IDLE.

## Timing
- Reset: on the rst edge, state = IDLE, and busy, tx_valid, tx_last, stall, done and set_valid = 0. tx_data, set_ctrl and set_data = 0.
- Reset mid-TX or mid-RX aborts the request: no done, no set_valid, and set_data keeps its reset value of 0.
- enable sampled high at edge t:
  - busy = 1 from t+1 (DECODE).
  - For a non-zero IN response, tx_valid = 1 from t+2, with the first byte on tx_data.
- tx_data and tx_last stay stable while tx_valid && !tx_ready.
- tx_valid stays high with no gaps between accepted bytes; the next byte is presented in the cycle after each handshake.
- The tx_last handshake at edge k:
  - k+1 is DONE: tx_valid = 0, done = 1.
  - k+2 is IDLE: busy = 0, and the engine can accept enable at that edge.
- Stall or zero-length request: DONE at t+2, IDLE at t+3.
- SET_CUR: RX from t+2. The final byte at edge k gives DONE with set_valid = 1 at k+1; set_data is valid from k+1.
- Minimum spacing between accepted enable strobes: 3 cycles.

## Test plan
- GET_INFO (PARAM_BYTES=8, NUM_CTRL=4): data = A1 87 0100 0000 0002, info_block byte 1 = 0x03, tx_ready=1 -> a single byte 0x03 with tx_last=1, then done one cycle later; stall stays 0.
- GET_CUR truncation: ctrl 2 with param bytes 0x11..0x88.
  - wLength=3 -> bytes 11,22,33, tx_last on 0x33.
  - wLength=64 -> 8 bytes, tx_last on 0x88.
- Backpressure: GET_LEN with tx_ready toggled 1-0-0-1 -> bytes 0x08, 0x00 are held stable while not ready, with no duplicates or drops.
- Rejects, each giving stall=1 and done=1 at t+2 with no tx_valid:
  - bRequest 0x83
  - ctrl=4
  - bmRequestType 0xA2
  - SET_CUR with wLength=4
- SET_CUR ctrl 1, rx bytes 01..08 with rx_valid gaps -> set_valid pulse, set_ctrl=1, set_data=0x0807060504030201.
- Reset mid-GET_CUR after 2 bytes -> all outputs 0 next cycle, no done. A following GET_INFO completes normally.
